morse_key_classifier: RTL and testbench

Front-end stage directly upstream of the Morse decoder. Takes the raw, asynchronous straight-key input. It synchronises and debounces the key, then measures mark and space durations on a prescaled tick. It emits one-cycle symbol codes on the 2-bit bus the decoder consumes: dot, dash, and character gap. It also flags word gaps and stuck keys.

---
 rtl/morse_key_classifier.sv | 160 ++++++++++++++++
 tb/tb_morse_key_classifier.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/morse_key_classifier.sv
// Straight-key front end: synchronise and debounce the key, then time marks and spaces
// on a prescaled tick to produce dot/dash/gap symbols, word-gap and stuck-key pulses.
module morse_key_classifier #(
   parameter int TICK_DIV       = 1,
   parameter int DEBOUNCE_TICKS = 2,
   parameter int DASH_TICKS     = 6,
   parameter int CHAR_GAP_TICKS = 10,
   parameter int WORD_GAP_TICKS = 25,
   parameter int STUCK_TICKS    = 40,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   output logic [1:0] morse_signal,
   output logic       word_gap,
   output logic       key_level,
   output logic       stuck_err
);

   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;
   localparam logic [1:0] SYM_GAP  = 2'b11;

   typedef enum logic [1:0] {IDLE, MARK, SPACE, WAIT_WORD} state_t;

   logic [1:0]       sync_reg;
   logic [CNT_W-1:0] pre_cnt_reg;
   logic [CNT_W-1:0] deb_cnt_reg;
   logic             key_level_reg;
   logic             key_level_d_reg;
   logic             key_sync;
   logic             tick;
   logic             rise;
   logic             fall;

   state_t           state_reg;
   logic [CNT_W-1:0] mark_cnt_reg;
   logic [CNT_W-1:0] space_cnt_reg;
   logic             stuck_seen_reg;
   logic [1:0]       morse_signal_reg;
   logic             word_gap_reg;
   logic             stuck_err_reg;
   logic [CNT_W-1:0] mark_inc;
   logic [CNT_W-1:0] space_inc;

   assign key_sync  = sync_reg[1];
   assign tick      = (pre_cnt_reg == CNT_W'(TICK_DIV - 1));
   assign rise      = key_level_reg & ~key_level_d_reg;
   assign fall      = ~key_level_reg & key_level_d_reg;
   assign mark_inc  = (mark_cnt_reg == '1) ? mark_cnt_reg : mark_cnt_reg + 1'b1;
   assign space_inc = (space_cnt_reg == '1) ? space_cnt_reg : space_cnt_reg + 1'b1;

   // Synchroniser, free-running prescaler and debounce filter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg        <= 2'b00;
         pre_cnt_reg     <= '0;
         deb_cnt_reg     <= '0;
         key_level_reg   <= 1'b0;
         key_level_d_reg <= 1'b0;
      end else begin
         sync_reg        <= {sync_reg[0], key_in};
         key_level_d_reg <= key_level_reg;
         if (tick) begin
            pre_cnt_reg <= '0;
         end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
         end
         if (tick) begin
            if (key_sync != key_level_reg) begin
               // The tick that completes the run flips the level, so both edges see the same delay.
               if (deb_cnt_reg >= CNT_W'(DEBOUNCE_TICKS - 1)) begin
                  key_level_reg <= ~key_level_reg;
                  deb_cnt_reg   <= '0;
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + 1'b1;
               end
            end else begin
               deb_cnt_reg <= '0;
            end
         end
      end
   end

   // Symbol timing FSM; a rising edge always takes priority over a gap threshold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         mark_cnt_reg     <= '0;
         space_cnt_reg    <= '0;
         stuck_seen_reg   <= 1'b0;
         morse_signal_reg <= SYM_NONE;
         word_gap_reg     <= 1'b0;
         stuck_err_reg    <= 1'b0;
      end else begin
         morse_signal_reg <= SYM_NONE;
         word_gap_reg     <= 1'b0;
         stuck_err_reg    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rise) begin
                  state_reg      <= MARK;
                  mark_cnt_reg   <= '0;
                  stuck_seen_reg <= 1'b0;
               end
            end
            MARK: begin
               if (fall) begin
                  state_reg     <= SPACE;
                  space_cnt_reg <= '0;
                  if (!stuck_seen_reg) begin
                     morse_signal_reg <= (mark_cnt_reg < CNT_W'(DASH_TICKS)) ? SYM_DOT : SYM_DASH;
                  end
               end else if (tick) begin
                  mark_cnt_reg <= mark_inc;
                  if (mark_inc == CNT_W'(STUCK_TICKS) && !stuck_seen_reg) begin
                     stuck_err_reg  <= 1'b1;
                     stuck_seen_reg <= 1'b1;
                  end
               end
            end
            SPACE: begin
               if (rise) begin
                  state_reg      <= MARK;
                  mark_cnt_reg   <= '0;
                  stuck_seen_reg <= 1'b0;
               end else if (tick) begin
                  space_cnt_reg <= space_inc;
                  if (space_inc == CNT_W'(CHAR_GAP_TICKS)) begin
                     morse_signal_reg <= SYM_GAP;
                     state_reg        <= WAIT_WORD;
                  end
               end
            end
            WAIT_WORD: begin
               if (rise) begin
                  state_reg      <= MARK;
                  mark_cnt_reg   <= '0;
                  stuck_seen_reg <= 1'b0;
               end else if (tick) begin
                  space_cnt_reg <= space_inc;
                  if (space_inc == CNT_W'(WORD_GAP_TICKS)) begin
                     word_gap_reg <= 1'b1;
                     state_reg    <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign morse_signal = morse_signal_reg;
   assign word_gap     = word_gap_reg;
   assign key_level    = key_level_reg;
   assign stuck_err    = stuck_err_reg;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Scoreboard bench: stimulus is a list of (mark, space) lengths; expected events come from timing rules.
module tb_morse_key_classifier;

   localparam int DASH  = 6;
   localparam int CHAR  = 10;
   localparam int WORD  = 25;
   localparam int STUCK = 40;
   localparam int DLY   = 4;   // 2-flop synchroniser + 2-tick debounce

   localparam int EV_DOT = 1, EV_DASH = 2, EV_GAP = 3, EV_WORD = 4, EV_STUCK = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_in = 1'b0;
   logic [1:0] morse_signal;
   logic       word_gap;
   logic       key_level;
   logic       stuck_err;

   typedef struct {int kind; int at;} ev_t;
   ev_t exp_q[$];
   bit  eff[0:65535];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   morse_key_classifier #(
      .TICK_DIV(1), .DEBOUNCE_TICKS(2), .DASH_TICKS(DASH), .CHAR_GAP_TICKS(CHAR),
      .WORD_GAP_TICKS(WORD), .STUCK_TICKS(STUCK), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .morse_signal(morse_signal),
      .word_gap(word_gap), .key_level(key_level), .stuck_err(stuck_err)
   );

   function automatic string kname(int k);
      case (k)
         EV_DOT:   return "dot";
         EV_DASH:  return "dash";
         EV_GAP:   return "char_gap";
         EV_WORD:  return "word_gap";
         EV_STUCK: return "stuck_err";
         default:  return "none";
      endcase
   endfunction

   task automatic check_ev(input int kind);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL event: got %s at cycle %0d, required nothing", kname(kind), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.at != cyc) begin
            bad++;
            $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                     kname(kind), cyc, kname(e.kind), e.at);
         end else begin
            $display("event %s at cycle %0d ok", kname(kind), cyc);
         end
      end
   endtask

   // Monitor: outputs sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         total++;
         if (morse_signal != 2'b00 || word_gap || stuck_err || key_level) begin
            bad++;
            $display("FAIL reset_outputs: got morse=%b word=%b stuck=%b level=%b, required all 0",
                     morse_signal, word_gap, stuck_err, key_level);
         end
      end else begin
         total++;
         if (key_level !== ((cyc >= DLY) ? eff[cyc-DLY] : 1'b0)) begin
            bad++;
            $display("FAIL key_level: got %b at cycle %0d, required %b",
                     key_level, cyc, (cyc >= DLY) ? eff[cyc-DLY] : 1'b0);
         end
         if (morse_signal != 2'b00) check_ev(int'(morse_signal));
         if (word_gap)  check_ev(EV_WORD);
         if (stuck_err) check_ev(EV_STUCK);
      end
   end

   task automatic drive(input bit v, input bit e);
      key_in   = v;
      eff[cyc] = e;
      @(posedge clk);
      #1;
   endtask

   // A run of level v; an optional single-cycle opposite glitch at least 2 cycles from either end.
   task automatic segment(input bit v, input int len, input bit glitch);
      int gp;
      gp = glitch ? int'($urandom_range(len - 3, 2)) : -1;
      for (int i = 0; i < len; i++) drive((i == gp) ? ~v : v, v);
   endtask

   // Raw mark of d cycles followed by raw space of s cycles.
   // Debounced edges lag raw edges by DLY; the mark measures d-1 ticks, the space s-1 ticks.
   task automatic pair(input int d, input int s, input bit gm, input bit gs);
      int n, n2;
      ev_t e;
      n = cyc;
      n2 = n + d;
      if (d - 1 >= STUCK) begin
         e.kind = EV_STUCK; e.at = n + DLY + STUCK + 1; exp_q.push_back(e);
      end else begin
         e.kind = (d - 1 < DASH) ? EV_DOT : EV_DASH; e.at = n2 + DLY + 1; exp_q.push_back(e);
      end
      if (s - 1 >= CHAR) begin
         e.kind = EV_GAP; e.at = n2 + DLY + CHAR + 1; exp_q.push_back(e);
      end
      if (s - 1 >= WORD) begin
         e.kind = EV_WORD; e.at = n2 + DLY + WORD + 1; exp_q.push_back(e);
      end
      segment(1'b1, d, gm && d >= 6);
      segment(1'b0, s, gs && s >= 6);
   endtask

   initial begin
      int d, s, sel;
      @(posedge clk);
      #1;
      // Reset held while the key toggles.
      for (int i = 0; i < 8; i++) drive(1'($urandom_range(1, 0)), 1'b0);
      key_in = 1'b0;
      rst_n  = 1'b1;
      for (int i = 0; i < 30; i++) drive(1'b0, 1'b0);

      // Directed: dot, dash, dot-dash, threshold boundaries, stuck keys.
      pair(4, 40, 0, 0);
      pair(8, 40, 0, 0);
      pair(4, 5, 0, 0);
      pair(8, 40, 0, 0);
      pair(6, 11, 0, 0);
      pair(7, 10, 0, 0);
      pair(2, 26, 0, 0);
      pair(3, 27, 0, 0);
      pair(40, 40, 0, 0);
      pair(41, 40, 0, 0);
      pair(50, 40, 0, 0);
      // Lone 1-cycle glitch while idle.
      segment(1'b0, 12, 1'b1);

      // Random symbol stream with occasional glitches inside runs.
      for (int k = 0; k < 45; k++) begin
         sel = int'($urandom_range(9, 0));
         d = (sel == 0) ? int'($urandom_range(50, 41)) : int'($urandom_range(12, 2));
         sel = int'($urandom_range(4, 0));
         case (sel)
            0: s = int'($urandom_range(9, 2));
            1: s = int'($urandom_range(12, 10));
            2: s = int'($urandom_range(24, 13));
            3: s = int'($urandom_range(27, 25));
            default: s = int'($urandom_range(40, 30));
         endcase
         pair(d, s, ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
      end
      pair(5, 40, 0, 0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);

      // Reset in the middle of a mark discards it.
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
      rst_n  = 1'b0;
      key_in = 1'b0;
      for (int i = 1; i <= 8; i++) eff[cyc-i] = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) drive(1'b0, 1'b0);

      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_event: got nothing, required %s at cycle %0d", kname(e.kind), e.at);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
